// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit restoring divider for the Execute stage: one quotient bit per cycle, stalling the pipe while it runs.
// Optional build macro SIGNED_DIV_EN enables signed divides selected by DivSignedE.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        DivStartE,
    input  logic        DivSignedE,
    input  logic        KillE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    output logic        BusyE,
    output logic        DivDoneE,
    output logic [31:0] QuotientE,
    output logic [31:0] RemainderE,
    output logic        DivByZeroE
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [31:0] dvd, dvs, rem;
    logic        neg_q, neg_r;

    logic [31:0] a_in, b_in;
    logic        nq_in, nr_in;

`ifdef SIGNED_DIV_EN
    // Divide magnitudes; signs are reapplied to the final quotient/remainder.
    always_comb begin
        nq_in = DivSignedE & (SrcAE[31] ^ SrcBE[31]);
        nr_in = DivSignedE & SrcAE[31];
        a_in  = (DivSignedE & SrcAE[31]) ? -SrcAE : SrcAE;
        b_in  = (DivSignedE & SrcBE[31]) ? -SrcBE : SrcBE;
    end
`else
    logic unused_signed;
    assign unused_signed = DivSignedE;
    assign nq_in = 1'b0;
    assign nr_in = 1'b0;
    assign a_in  = SrcAE;
    assign b_in  = SrcBE;
`endif

    logic        start_ok;
    logic        zero_div;
    assign start_ok = DivStartE & ~KillE;
    assign zero_div = (SrcBE == 32'd0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] rem_sh, diff;
    logic        qbit;
    logic [31:0] rem_step, dvd_step;
    always_comb begin
        rem_sh   = {rem, dvd[31]};
        diff     = rem_sh - {1'b0, dvs};
        qbit     = ~diff[32];
        rem_step = qbit ? diff[31:0] : rem_sh[31:0];
        dvd_step = {dvd[30:0], qbit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        BusyE      = 1'b0;
        DivDoneE   = 1'b0;
        case (state)
            IDLE: if (start_ok) begin
                BusyE      = 1'b1;
                state_next = zero_div ? DONE : RUN;
            end
            RUN: begin
                BusyE = 1'b1;
                if (KillE)              state_next = IDLE;
                else if (count == 6'd0) state_next = DONE;
            end
            DONE: begin
                DivDoneE   = ~KillE;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Keep the stall/strobe quiet while reset is held, whatever DivStartE does.
        if (reset) begin
            BusyE    = 1'b0;
            DivDoneE = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= 6'd0;
            dvd        <= 32'd0;
            dvs        <= 32'd0;
            rem        <= 32'd0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            QuotientE  <= 32'd0;
            RemainderE <= 32'd0;
            DivByZeroE <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    dvd   <= a_in;
                    dvs   <= b_in;
                    rem   <= 32'd0;
                    count <= 6'd31;
                    neg_q <= nq_in;
                    neg_r <= nr_in;
                    if (zero_div) begin
                        QuotientE  <= 32'd0;
                        RemainderE <= SrcAE;
                        DivByZeroE <= 1'b1;
                    end
                end
                RUN: if (!KillE) begin
                    dvd   <= dvd_step;
                    rem   <= rem_step;
                    count <= count - 6'd1;
                    if (count == 6'd0) begin
                        QuotientE  <= neg_q ? -dvd_step : dvd_step;
                        RemainderE <= neg_r ? -rem_step : rem_step;
                        DivByZeroE <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: scoreboarded divides, kill/reset aborts, zero divisor and signed build (SIGNED_DIV_EN).
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        DivStartE, DivSignedE, KillE;
    logic [31:0] SrcAE, SrcBE;
    logic        BusyE, DivDoneE, DivByZeroE;
    logic [31:0] QuotientE, RemainderE;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;
    exp_t sb[$];

    div_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .DivStartE  (DivStartE),
        .DivSignedE (DivSignedE),
        .KillE      (KillE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .BusyE      (BusyE),
        .DivDoneE   (DivDoneE),
        .QuotientE  (QuotientE),
        .RemainderE (RemainderE),
        .DivByZeroE (DivByZeroE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Start a divide with DivStartE held until DivDoneE, then drop it and confirm IDLE.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int elat, input int ebusy);
        exp_t e;
        int   lat, busy;
        logic done;
        e.q = eq; e.r = er; e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        SrcAE = a; SrcBE = b; DivSignedE = s; DivStartE = 1'b1; KillE = 1'b0;
        lat = 0; busy = 0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (DivDoneE) begin
                done = 1'b1;
                break;
            end
            if (BusyE) busy++;
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, " done"}, 32'(done), 32'd1);
        if (done) begin
            check({tag, " latency"}, lat + 1, elat);
            check({tag, " busy cycles"}, busy, ebusy);
            check({tag, " busy in done"}, 32'(BusyE), 32'd0);
            check({tag, " quotient"}, QuotientE, e.q);
            check({tag, " remainder"}, RemainderE, e.r);
            check({tag, " divbyzero"}, 32'(DivByZeroE), 32'(e.dbz));
        end
        @(negedge clk);
        DivStartE = 1'b0;
        #1;
        check({tag, " idle after done"}, {30'd0, BusyE, DivDoneE}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        seen;

        reset = 1'b1; DivStartE = 1'b0; DivSignedE = 1'b0; KillE = 1'b0;
        SrcAE = 32'd0; SrcBE = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", 32'(BusyE), 32'd0);
        check("reset done", 32'(DivDoneE), 32'd0);
        check("reset quotient", QuotientE, 32'd0);
        check("reset remainder", RemainderE, 32'd0);
        check("reset dbz", 32'(DivByZeroE), 32'd0);
        reset = 1'b0;

        do_div("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33);
        do_div("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 33);
        do_div("div0", 32'h1234, 32'd0, 1'b0, 32'd0, 32'h1234, 1'b1, 2, 1);

        // Kill at RUN cycle 10: back to IDLE, no strobe, results untouched.
        @(negedge clk);
        SrcAE = 32'd100; SrcBE = 32'd7; DivStartE = 1'b1;
        #1;
        check("kill start busy", 32'(BusyE), 32'd1);
        @(negedge clk);
        DivStartE = 1'b0;
        repeat (9) @(negedge clk);
        KillE = 1'b1;
        #1;
        check("kill no strobe", 32'(DivDoneE), 32'd0);
        @(negedge clk);
        KillE = 1'b0;
        #1;
        check("kill idle", 32'(BusyE), 32'd0);
        check("kill quotient held", QuotientE, 32'd0);
        check("kill remainder held", RemainderE, 32'h1234);
        check("kill dbz held", 32'(DivByZeroE), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (DivDoneE || BusyE) seen = 1'b1;
        end
        check("kill no later done", 32'(seen), 32'd0);

        // Kill together with start in IDLE: nothing starts.
        @(negedge clk);
        SrcAE = 32'd50; SrcBE = 32'd5; DivStartE = 1'b1; KillE = 1'b1;
        #1;
        check("kill+start busy", 32'(BusyE), 32'd0);
        @(negedge clk);
        DivStartE = 1'b0; KillE = 1'b0;
        #1;
        check("kill+start no run", {30'd0, BusyE, DivDoneE}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> (i * 8);
            if (rb == 32'd0) rb = 32'd3;
            do_div("random", ra, rb, 1'b0, ra / rb, ra % rb, 1'b0, 34, 33);
        end

`ifdef SIGNED_DIV_EN
        do_div("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33);
        do_div("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 33);
        do_div("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 33);
        do_div("u -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 33);
`else
        do_div("ign -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 33);
        do_div("ign min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34, 33);
`endif
        DivSignedE = 1'b0;

        // Reset at RUN cycle 5 clears everything at once.
        @(negedge clk);
        SrcAE = 32'd999; SrcBE = 32'd10; DivStartE = 1'b1;
        @(negedge clk);
        DivStartE = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre-reset busy", 32'(BusyE), 32'd1);
        reset = 1'b1;
        #1;
        check("mid reset busy", 32'(BusyE), 32'd0);
        check("mid reset done", 32'(DivDoneE), 32'd0);
        check("mid reset quotient", QuotientE, 32'd0);
        check("mid reset remainder", RemainderE, 32'd0);
        check("mid reset dbz", 32'(DivByZeroE), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post reset idle", {30'd0, BusyE, DivDoneE}, 32'd0);

        do_div("recover", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the Reset values below.
REQ-004 DivStartE  in  1  a divide instruction is in Execute and its condition has passed.
REQ-005 DivSignedE  in  1  signed-divide request; used only under REQ-026.
REQ-006 KillE  in  1  Execute flush; aborts any divide in progress.
REQ-007 SrcAE  in  32  dividend.
REQ-008 SrcBE  in  32  divisor.
REQ-009 BusyE  out  1  stall request to the F/D/E pipeline registers.
REQ-010 DivDoneE  out  1  one-cycle strobe: the quotient and remainder outputs are valid.
REQ-011 QuotientE  out  32  registered quotient.
REQ-012 RemainderE  out  32  registered remainder.
REQ-013 DivByZeroE  out  1  the last completed divide had SrcBE == 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 Transitions SHALL be:
- IDLE -> RUN on DivStartE & !KillE & SrcBE != 0.
- IDLE -> DONE on DivStartE & !KillE & SrcBE == 0.
- RUN -> DONE when the counter reaches 0.
- DONE -> IDLE unconditionally.
REQ-016 On leaving IDLE the block SHALL latch both operands, clear the partial remainder and load the 6-bit counter with 31.
REQ-017 Each RUN cycle SHALL perform one restoring-division step, producing one quotient bit MSB-first, then decrement the counter; RUN SHALL last exactly 32 cycles.
REQ-018 BusyE SHALL be combinational and equal (IDLE & DivStartE & !KillE) | RUN; it SHALL be 0 in DONE so the instruction advances that cycle.
REQ-019 DivDoneE SHALL be 1 only in DONE; QuotientE, RemainderE and DivByZeroE SHALL update on entry to DONE and hold until the next DONE.
REQ-020 Latency from the cycle DivStartE is sampled to DivDoneE SHALL be:
- nonzero divisor: start cycle + 32 RUN + 1 DONE = 34 cycles in Execute;
- zero divisor: 2 cycles.
REQ-021 Divide by zero SHALL give QuotientE = 0, RemainderE = dividend and DivByZeroE = 1; any other completed divide SHALL clear DivByZeroE.
REQ-022 A DivStartE still high in DONE SHALL NOT start a new divide; a back-to-back divide SHALL start from IDLE on the following cycle.
REQ-023 KillE in RUN or DONE SHALL force IDLE on the next edge, suppress DivDoneE and leave the result outputs unchanged.
REQ-024 KillE and DivStartE asserted together in IDLE SHALL NOT start a divide, and BusyE SHALL stay 0.

Reset
REQ-025 Reset SHALL take effect immediately, including mid-divide. On reset:
- state = IDLE;
- counter = 0;
- internal operand and partial-remainder registers = 0;
- BusyE = 0, DivDoneE = 0;
- QuotientE = 0, RemainderE = 0, DivByZeroE = 0.

Configuration
REQ-026 With SIGNED_DIV_EN defined, a divide started with DivSignedE = 1 SHALL:
- divide the operand magnitudes;
- negate the quotient when the operand signs differ;
- give the remainder the dividend's sign;
- return 0x80000000 / 0xFFFFFFFF as quotient 0x80000000, remainder 0.
Without SIGNED_DIV_EN, DivSignedE SHALL be ignored and every divide SHALL be unsigned.

Verification
REQ-027 The bench SHALL cover at least these scenarios:
- SrcAE = 100, SrcBE = 7, DivStartE pulse held until done -> BusyE high for 33 cycles, then DivDoneE, QuotientE = 14, RemainderE = 2, DivByZeroE = 0.
- SrcAE = 0xFFFFFFFF, SrcBE = 1 -> QuotientE = 0xFFFFFFFF, RemainderE = 0.
- SrcAE = 0x1234, SrcBE = 0 -> DivDoneE on 2nd cycle, QuotientE = 0, RemainderE = 0x1234, DivByZeroE = 1.
- KillE at RUN cycle 10 -> IDLE next cycle, no DivDoneE, outputs keep their prior values.
- reset asserted at RUN cycle 5 -> BusyE = 0 immediately, all outputs 0.
- SIGNED_DIV_EN, DivSignedE = 1, SrcAE = -7, SrcBE = 2 -> QuotientE = -3 (0xFFFFFFFD), RemainderE = -1 (0xFFFFFFFF).
- without SIGNED_DIV_EN, same operands -> unsigned result QuotientE = 0x7FFFFFFC, RemainderE = 1.
